// File: rtl/ldst_mem_resp_pkg.sv
// ---------------------------------------------------------------------------
// ldst_mem_resp_pkg
// Shared types for the load/store memory responder:
//   data_t            - one memory word / load-store element
//   address_t         - descriptor and address arithmetic type (mod 2^32)
//   ldst_resp_state_t - responder FSM states
//   ldst_desc_t       - strided access descriptor {len, stride, base}
// Helper:
//   addr_out_of_range - true when an address has bits set above the index
// ---------------------------------------------------------------------------
package ldst_mem_resp_pkg;

    typedef logic [31:0] data_t;
    typedef logic [31:0] address_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        STORE,
        DRAIN
    } ldst_resp_state_t;

    typedef struct packed {
        address_t len;
        address_t stride;
        address_t base;
    } ldst_desc_t;

    // An address is out of range when anything above the memory index is set.
    function automatic logic addr_out_of_range(input address_t addr,
                                               input int unsigned width_addr);
        return (addr >> width_addr) != '0;
    endfunction

endpackage

// File: rtl/ldst_sram.sv
// ---------------------------------------------------------------------------
// ldst_sram
// Single-port local data memory, 2^WIDTH_ADDR words of data_t.
// Ports:
//   clock, reset - rising-edge clock, synchronous active-high reset
//                  (reset clears only the read data register)
//   rd_en        - issue a read of addr; data appears one cycle later
//   wr_en        - write wr_data to addr
//   addr         - word index
//   wr_data      - write data
//   rd_data      - registered read data, holds until the next read
// ---------------------------------------------------------------------------
module ldst_sram
    import ldst_mem_resp_pkg::*;
#(
    parameter int WIDTH_ADDR = 10
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  rd_en,
    input  logic                  wr_en,
    input  logic [WIDTH_ADDR-1:0] addr,
    input  data_t                 wr_data,
    output data_t                 rd_data
);

    data_t mem [0:(1 << WIDTH_ADDR)-1];

    // Storage array; no reset so it maps onto a plain RAM macro.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end

    // Read register only loads on a read, so the last value is held while
    // no read is issued. A simultaneous write is seen as the old contents.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[addr];
        end
    end

endmodule

// File: rtl/ldst_mem_resp.sv
// ---------------------------------------------------------------------------
// ldst_mem_resp
// Memory-side responder for the load/store command interface. Captures one
// pending strided descriptor per direction, arbitrates them onto a single
// port memory, and returns per-element grants, load data and End_Access.
// Optional feature macro: LDST_RESP_BOUNDS_CHECK_EN (address range checking,
// sticky O_Err, out-of-range elements suppressed).
// Ports:
//   clock, reset                      - clock, synchronous active-high reset
//   I_Stall                           - freeze element progress
//   I_Ld_Req/Len/Stride/Base          - load descriptor strobe and fields
//   O_Ld_Ready, O_Ld_Grant, O_Ld_Data - load slot free, data valid, data
//   I_St_Req/Len/Stride/Base          - store descriptor strobe and fields
//   I_St_Data                         - current store element
//   O_St_Ready, O_St_Grant            - store slot free, element consumed
//   O_End_Access                      - pulse after the last element
//   O_Busy                            - active access or pending slot
//   O_Err                             - sticky range error (0 without macro)
// ---------------------------------------------------------------------------
module ldst_mem_resp
    import ldst_mem_resp_pkg::*;
#(
    parameter int WIDTH_ADDR    = 10,
    parameter bit INIT_LD_FIRST = 1'b1
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     I_Stall,
    input  logic     I_Ld_Req,
    input  address_t I_Ld_Len,
    input  address_t I_Ld_Stride,
    input  address_t I_Ld_Base,
    output logic     O_Ld_Ready,
    output logic     O_Ld_Grant,
    output data_t    O_Ld_Data,
    input  logic     I_St_Req,
    input  address_t I_St_Len,
    input  address_t I_St_Stride,
    input  address_t I_St_Base,
    input  data_t    I_St_Data,
    output logic     O_St_Ready,
    output logic     O_St_Grant,
    output logic     O_End_Access,
    output logic     O_Busy,
    output logic     O_Err
);

    ldst_resp_state_t state_q, state_d;
    ldst_desc_t       ld_desc_q, st_desc_q, ld_in, st_in, ld_now, st_now, sel_desc;
    logic             ld_pend_q, st_pend_q;
    logic             ld_cap, st_cap, ld_avail, st_avail;
    logic             ld_prio_q, served_ld_q, pick_ld, start;
    logic             rd_issue, wr_grant, rd_valid_q, elem_oob;
    address_t         addr_q, cnt_q, cur_stride;
    data_t            sram_rd_data;

    assign ld_in = '{len: I_Ld_Len, stride: I_Ld_Stride, base: I_Ld_Base};
    assign st_in = '{len: I_St_Len, stride: I_St_Stride, base: I_St_Base};

    // A request is only taken into an empty slot; a request arriving this
    // cycle is already visible to the arbiter so an idle responder can start
    // on the very next cycle.
    assign ld_cap   = I_Ld_Req && !ld_pend_q;
    assign st_cap   = I_St_Req && !st_pend_q;
    assign ld_avail = ld_pend_q || I_Ld_Req;
    assign st_avail = st_pend_q || I_St_Req;
    assign ld_now   = ld_pend_q ? ld_desc_q : ld_in;
    assign st_now   = st_pend_q ? st_desc_q : st_in;

    assign cur_stride = served_ld_q ? ld_desc_q.stride : st_desc_q.stride;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-cycle strobes. On a tie the arbiter picks the
    // direction that was not served most recently; a zero-length access
    // skips straight to DRAIN so it still produces its End_Access.
    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        pick_ld  = 1'b0;
        sel_desc = '0;
        rd_issue = 1'b0;
        wr_grant = 1'b0;
        case (state_q)
            IDLE: begin
                if (ld_avail || st_avail) begin
                    start    = 1'b1;
                    pick_ld  = ld_avail && (!st_avail || ld_prio_q);
                    sel_desc = pick_ld ? ld_now : st_now;
                    if (sel_desc.len == '0) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = pick_ld ? LOAD : STORE;
                    end
                end
            end
            LOAD: begin
                if (!I_Stall) begin
                    rd_issue = 1'b1;
                    if (cnt_q == address_t'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            STORE: begin
                if (!I_Stall) begin
                    wr_grant = 1'b1;
                    if (cnt_q == address_t'(1)) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Descriptor slots and arbitration history. The served slot stays full
    // for the whole access so Ready only returns after End_Access.
    always_ff @(posedge clock) begin
        if (reset) begin
            ld_pend_q   <= 1'b0;
            st_pend_q   <= 1'b0;
            ld_desc_q   <= '0;
            st_desc_q   <= '0;
            ld_prio_q   <= INIT_LD_FIRST;
            served_ld_q <= 1'b0;
        end else begin
            if (ld_cap) begin
                ld_pend_q <= 1'b1;
                ld_desc_q <= ld_in;
            end
            if (st_cap) begin
                st_pend_q <= 1'b1;
                st_desc_q <= st_in;
            end
            if (state_q == DRAIN) begin
                if (served_ld_q) begin
                    ld_pend_q <= 1'b0;
                end else begin
                    st_pend_q <= 1'b0;
                end
            end
            if (start) begin
                served_ld_q <= pick_ld;
                ld_prio_q   <= !pick_ld;
            end
        end
    end

    // Element address and remaining count; both hold while stalled.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q     <= '0;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_issue;
            if (start) begin
                addr_q <= sel_desc.base;
                cnt_q  <= sel_desc.len;
            end else if (rd_issue || wr_grant) begin
                addr_q <= addr_q + cur_stride;
                cnt_q  <= cnt_q - address_t'(1);
            end
        end
    end

    ldst_sram #(
        .WIDTH_ADDR (WIDTH_ADDR)
    ) u_sram (
        .clock   (clock),
        .reset   (reset),
        .rd_en   (rd_issue),
        .wr_en   (wr_grant && !elem_oob),
        .addr    (addr_q[WIDTH_ADDR-1:0]),
        .wr_data (I_St_Data),
        .rd_data (sram_rd_data)
    );

`ifdef LDST_RESP_BOUNDS_CHECK_EN
    logic err_q, oob_rd_q;

    assign elem_oob = addr_out_of_range(addr_q, WIDTH_ADDR);

    // Remember whether the read in flight was out of range so its data is
    // forced to zero, and hold the sticky error until reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_q    <= 1'b0;
            oob_rd_q <= 1'b0;
        end else begin
            if ((rd_issue || wr_grant) && elem_oob) begin
                err_q <= 1'b1;
            end
            if (rd_issue) begin
                oob_rd_q <= elem_oob;
            end
        end
    end

    assign O_Err     = err_q;
    assign O_Ld_Data = oob_rd_q ? '0 : sram_rd_data;
`else
    assign elem_oob  = 1'b0;
    assign O_Err     = 1'b0;
    assign O_Ld_Data = sram_rd_data;
`endif

    assign O_Ld_Ready   = !ld_pend_q;
    assign O_St_Ready   = !st_pend_q;
    assign O_Ld_Grant   = rd_valid_q;
    assign O_St_Grant   = wr_grant;
    assign O_End_Access = (state_q == DRAIN);
    assign O_Busy       = (state_q != IDLE) || ld_pend_q || st_pend_q;

endmodule

// File: tb/tb_ldst_mem_resp.sv
// ---------------------------------------------------------------------------
// tb_ldst_mem_resp
// Self-checking bench for ldst_mem_resp: directed steps followed by random
// strided accesses, all compared against a word-array reference model of
// the memory plus a stall-driven schedule of expected grant cycles.
// Honours LDST_RESP_BOUNDS_CHECK_EN when predicting O_Err and suppression.
// ---------------------------------------------------------------------------
module tb_ldst_mem_resp;
    import ldst_mem_resp_pkg::*;

    localparam int WA    = 10;
    localparam int DEPTH = 1 << WA;
`ifdef LDST_RESP_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic     clock = 1'b0;
    logic     reset = 1'b1;
    logic     I_Stall = 1'b0;
    logic     I_Ld_Req = 1'b0;
    address_t I_Ld_Len = '0, I_Ld_Stride = '0, I_Ld_Base = '0;
    logic     I_St_Req = 1'b0;
    address_t I_St_Len = '0, I_St_Stride = '0, I_St_Base = '0;
    data_t    I_St_Data = '0;
    logic     O_Ld_Ready, O_Ld_Grant, O_St_Ready, O_St_Grant;
    logic     O_End_Access, O_Busy, O_Err;
    data_t    O_Ld_Data;

    ldst_mem_resp #(
        .WIDTH_ADDR    (WA),
        .INIT_LD_FIRST (1'b1)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .I_Stall      (I_Stall),
        .I_Ld_Req     (I_Ld_Req),
        .I_Ld_Len     (I_Ld_Len),
        .I_Ld_Stride  (I_Ld_Stride),
        .I_Ld_Base    (I_Ld_Base),
        .O_Ld_Ready   (O_Ld_Ready),
        .O_Ld_Grant   (O_Ld_Grant),
        .O_Ld_Data    (O_Ld_Data),
        .I_St_Req     (I_St_Req),
        .I_St_Len     (I_St_Len),
        .I_St_Stride  (I_St_Stride),
        .I_St_Base    (I_St_Base),
        .I_St_Data    (I_St_Data),
        .O_St_Ready   (O_St_Ready),
        .O_St_Grant   (O_St_Grant),
        .O_End_Access (O_End_Access),
        .O_Busy       (O_Busy),
        .O_Err        (O_Err)
    );

    always #5 clock = ~clock;

    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    int    t0 = 0;
    int    stall_lo = 1, stall_hi = 0;
    int    rand_stall_pct = 0;
    int    last_ld_busy, last_st_busy, last_busy;
    bit    exp_err = 1'b0;
    data_t mem_model [DEPTH];
    data_t st_src[$];
    int    st_idx;
    data_t ld_seen[$];
    data_t exp_ld[$];
    int    ld_grant_cyc[$], st_grant_cyc[$], end_cyc[$];
    bit    stall_log[$];

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i >= 0 && i < q.size()) return q[i];
        return -1;
    endfunction

    function automatic ldst_desc_t mk(input address_t len, input address_t stride,
                                      input address_t base);
        ldst_desc_t d;
        d.len = len;
        d.stride = stride;
        d.base = base;
        return d;
    endfunction

    function automatic bit oob(input address_t a);
        return BOUNDS && ((a >> WA) != 0);
    endfunction

    // Reference model: element i lives at base + i*stride (mod 2^32),
    // stored at the low WA bits of that address.
    task automatic model_store(input ldst_desc_t d);
        address_t a;
        for (int i = 0; i < int'(d.len); i++) begin
            a = d.base + address_t'(i) * d.stride;
            if (oob(a)) exp_err = 1'b1;
            else mem_model[a[WA-1:0]] = st_src[i];
        end
    endtask

    task automatic model_load(input ldst_desc_t d);
        address_t a;
        exp_ld.delete();
        for (int i = 0; i < int'(d.len); i++) begin
            a = d.base + address_t'(i) * d.stride;
            if (oob(a)) begin
                exp_err = 1'b1;
                exp_ld.push_back('0);
            end else begin
                exp_ld.push_back(mem_model[a[WA-1:0]]);
            end
        end
    endtask

    task automatic clear_log();
        ld_seen.delete();
        ld_grant_cyc.delete();
        st_grant_cyc.delete();
        end_cyc.delete();
        stall_log.delete();
        st_idx = 0;
        last_ld_busy = -1;
        last_st_busy = -1;
        last_busy = -1;
    endtask

    task automatic applyStimulus(input bit ld, input bit st,
                                 input ldst_desc_t ld_d, input ldst_desc_t st_d);
        I_Ld_Req = ld;
        I_Ld_Len = ld_d.len;
        I_Ld_Stride = ld_d.stride;
        I_Ld_Base = ld_d.base;
        I_St_Req = st;
        I_St_Len = st_d.len;
        I_St_Stride = st_d.stride;
        I_St_Base = st_d.base;
    endtask

    // One clock cycle: set stall/store data, sample outputs mid-cycle,
    // then advance past the next rising edge and drop the strobes.
    task automatic step();
        I_Stall = ((cyc >= stall_lo) && (cyc <= stall_hi)) ||
                  (int'($urandom_range(99)) < rand_stall_pct);
        I_St_Data = (st_idx < st_src.size()) ? st_src[st_idx] : '0;
        stall_log.push_back(I_Stall);
        @(negedge clock);
        if (O_Ld_Grant) begin
            ld_seen.push_back(O_Ld_Data);
            ld_grant_cyc.push_back(cyc);
        end
        if (O_St_Grant) begin
            st_grant_cyc.push_back(cyc);
            st_idx++;
        end
        if (I_Stall) checkOutput("st_grant_during_stall", {31'd0, O_St_Grant}, 32'd0);
        if (O_End_Access) end_cyc.push_back(cyc);
        if (!O_Ld_Ready) last_ld_busy = cyc;
        if (!O_St_Ready) last_st_busy = cyc;
        if (O_Busy) last_busy = cyc;
        @(posedge clock);
        #1;
        cyc++;
        I_Ld_Req = 1'b0;
        I_St_Req = 1'b0;
    endtask

    task automatic wait_ends(input int n, input int budget);
        int k = 0;
        while (end_cyc.size() < n && k < budget) begin
            step();
            k++;
        end
        checkOutput("end_access_seen", end_cyc.size(), n);
    endtask

    // Called with reset already high for at least one edge.
    task automatic check_reset_release();
        @(negedge clock);
        checkOutput("rst_ld_ready", {31'd0, O_Ld_Ready}, 32'd1);
        checkOutput("rst_st_ready", {31'd0, O_St_Ready}, 32'd1);
        checkOutput("rst_ld_grant", {31'd0, O_Ld_Grant}, 32'd0);
        checkOutput("rst_st_grant", {31'd0, O_St_Grant}, 32'd0);
        checkOutput("rst_end", {31'd0, O_End_Access}, 32'd0);
        checkOutput("rst_busy", {31'd0, O_Busy}, 32'd0);
        checkOutput("rst_err", {31'd0, O_Err}, 32'd0);
        checkOutput("rst_ld_data", O_Ld_Data, 32'd0);
        @(posedge clock);
        #1;
        cyc++;
        reset = 1'b0;
        exp_err = 1'b0;
    endtask

    // Single access from an idle responder. Elements are issued on the
    // unstalled cycles from t0+1 onward; loads are granted a cycle later;
    // End_Access follows the last issue; Ready and Busy return after it.
    task automatic applyAccess(input bit is_ld, input ldst_desc_t d, input int budget);
        int issue[$];
        int exp_end;
        int c;
        clear_log();
        t0 = cyc;
        if (is_ld) applyStimulus(1'b1, 1'b0, d, '0);
        else applyStimulus(1'b0, 1'b1, '0, d);
        wait_ends(1, budget);
        step();
        c = 1;
        while (issue.size() < int'(d.len)) begin
            if (c >= stall_log.size() || !stall_log[c]) issue.push_back(t0 + c);
            c++;
        end
        exp_end = (d.len == 0) ? t0 + 1 : issue[issue.size()-1] + 1;
        checkOutput("end_cycle", qget(end_cyc, 0), exp_end);
        checkOutput("busy_until_end", last_busy, exp_end);
        if (is_ld) begin
            model_load(d);
            checkOutput("ld_count", ld_seen.size(), exp_ld.size());
            for (int i = 0; i < ld_seen.size() && i < exp_ld.size(); i++)
                checkOutput("ld_data", ld_seen[i], exp_ld[i]);
            if (d.len != 0) begin
                checkOutput("ld_first_grant", qget(ld_grant_cyc, 0), issue[0] + 1);
                checkOutput("ld_last_grant", qget(ld_grant_cyc, ld_grant_cyc.size()-1),
                            issue[issue.size()-1] + 1);
            end
            checkOutput("ld_ready_back", last_ld_busy, exp_end);
        end else begin
            model_store(d);
            checkOutput("st_count", st_grant_cyc.size(), d.len);
            if (d.len != 0) begin
                checkOutput("st_first_grant", qget(st_grant_cyc, 0), issue[0]);
                checkOutput("st_last_grant", qget(st_grant_cyc, st_grant_cyc.size()-1),
                            issue[issue.size()-1]);
            end
            checkOutput("st_ready_back", last_st_busy, exp_end);
        end
    endtask

    initial begin
        ldst_desc_t d, ld_d, st_d;
        bit is_ld;
        address_t stride;

        $display("[TB] reset values");
        reset = 1'b1;
        step();
        step();
        check_reset_release();

        $display("[TB] fill memory with random words");
        st_src.delete();
        for (int i = 0; i < DEPTH; i++) st_src.push_back($urandom());
        applyAccess(1'b0, mk(DEPTH, 1, 0), DEPTH + 50);

        $display("[TB] store then load 4 words at 0x10");
        st_src = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        applyAccess(1'b0, mk(4, 1, 32'h10), 40);
        applyAccess(1'b1, mk(4, 1, 32'h10), 40);

        $display("[TB] simultaneous requests after reset");
        reset = 1'b1;
        step();
        check_reset_release();
        clear_log();
        st_src = '{32'hB0, 32'hB1, 32'hB2};
        ld_d = mk(2, 1, 32'h10);
        st_d = mk(3, 1, 32'h20);
        t0 = cyc;
        applyStimulus(1'b1, 1'b1, ld_d, st_d);
        wait_ends(2, 60);
        step();
        model_load(ld_d);
        checkOutput("tie_ld_count", ld_seen.size(), 2);
        for (int i = 0; i < ld_seen.size() && i < 2; i++)
            checkOutput("tie_ld_data", ld_seen[i], exp_ld[i]);
        checkOutput("tie_ld_grant0", qget(ld_grant_cyc, 0), t0 + 2);
        checkOutput("tie_ld_end", qget(end_cyc, 0), t0 + 3);
        checkOutput("tie_st_first", qget(st_grant_cyc, 0), t0 + 5);
        checkOutput("tie_st_count", st_grant_cyc.size(), 3);
        checkOutput("tie_st_end", qget(end_cyc, 1), t0 + 8);
        checkOutput("tie_st_ready_low", last_st_busy, t0 + 8);
        model_store(st_d);

        $display("[TB] negative stride load");
        st_src = '{32'hC0, 32'hC1, 32'hC2};
        applyAccess(1'b0, mk(3, 1, 0), 40);
        applyAccess(1'b1, mk(3, 32'hFFFF_FFFF, 2), 40);

        $display("[TB] stalled store of 8");
        st_src.delete();
        for (int i = 0; i < 8; i++) st_src.push_back($urandom());
        stall_lo = cyc + 3;
        stall_hi = cyc + 5;
        applyAccess(1'b0, mk(8, 2, 32'h40), 60);
        stall_lo = 1;
        stall_hi = 0;
        applyAccess(1'b1, mk(8, 2, 32'h40), 60);

        $display("[TB] zero-length load");
        applyAccess(1'b1, mk(0, 1, 0), 20);

        $display("[TB] reset during a store");
        clear_log();
        st_src.delete();
        for (int i = 0; i < 6; i++) st_src.push_back($urandom());
        applyStimulus(1'b0, 1'b1, '0, mk(6, 1, 32'h300));
        step();
        step();
        step();
        reset = 1'b1;
        step();
        check_reset_release();
        applyAccess(1'b0, mk(6, 1, 32'h300), 40);

        $display("[TB] random accesses");
        rand_stall_pct = 25;
        for (int n = 0; n < 24; n++) begin
            is_ld = 1'($urandom_range(1));
            case ($urandom_range(3))
                0: stride = 32'd1;
                1: stride = 32'hFFFF_FFFF;
                2: stride = address_t'($urandom_range(7, 2));
                default: stride = $urandom();
            endcase
            d = mk(address_t'($urandom_range(8, 1)), stride,
                   address_t'($urandom_range(DEPTH - 1)));
            st_src.delete();
            for (int i = 0; i < int'(d.len); i++) st_src.push_back($urandom());
            applyAccess(is_ld, d, 200);
        end
        rand_stall_pct = 0;

        $display("[TB] base beyond memory depth");
        st_src = '{32'h5555_AAAA};
        applyAccess(1'b0, mk(1, 1, DEPTH), 20);
        applyAccess(1'b1, mk(1, 1, 0), 20);
        applyAccess(1'b1, mk(1, 1, DEPTH), 20);
        @(negedge clock);
        checkOutput("err_flag", {31'd0, O_Err}, {31'd0, exp_err});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
